// File: rtl/mips_fields_pkg.sv
// MIPS instruction field layout shared by the IF->ID buffer and its field splitter.
package mips_fields_pkg;

  localparam int INSTR_W = 32;

  // Field bit positions within a 32-bit MIPS word
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADD_HI  = 25;
  localparam int JADD_LO  = 0;

  // Field widths
  localparam int OPC_W   = OPC_HI - OPC_LO + 1;
  localparam int REG_W   = RS_HI - RS_LO + 1;
  localparam int SHAMT_W = SHAMT_HI - SHAMT_LO + 1;
  localparam int FUNCT_W = FUNCT_HI - FUNCT_LO + 1;
  localparam int IMM_W   = IMM_HI - IMM_LO + 1;
  localparam int JADD_W  = JADD_HI - JADD_LO + 1;

  // Opcode constants
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // Decoded view of one instruction word
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [JADD_W-1:0]  jadd;
  } fields_t;

endpackage

// File: rtl/instr_fields.sv
// Purely combinational split of a 32-bit MIPS word into its fields and
// extended immediates.
module instr_fields
  import mips_fields_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields,
  output logic [INSTR_W-1:0] imm_sext,
  output logic [INSTR_W-1:0] imm_zext
);

  // Slice fields and extend the 16-bit immediate both ways
  always_comb begin
    fields.opcode = instr[OPC_HI:OPC_LO];
    fields.rs     = instr[RS_HI:RS_LO];
    fields.rt     = instr[RT_HI:RT_LO];
    fields.rd     = instr[RD_HI:RD_LO];
    fields.shamt  = instr[SHAMT_HI:SHAMT_LO];
    fields.funct  = instr[FUNCT_HI:FUNCT_LO];
    fields.imm    = instr[IMM_HI:IMM_LO];
    fields.jadd   = instr[JADD_HI:JADD_LO];
    imm_sext      = {{(INSTR_W-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
    imm_zext      = {{(INSTR_W-IMM_W){1'b0}}, instr[IMM_HI:IMM_LO]};
  end

endmodule

// File: rtl/instr_field_queue.sv
// IF->ID instruction buffer: circular queue of {pc, instr} with the head entry
// presented pre-split into MIPS fields, extended immediates and J target.
//
// Handshake: a transfer happens on a rising edge when valid & ready are both
// high. in_ready depends only on occupancy (never on out_ready), out_valid only
// on occupancy, and the head holds stable while out_valid & ~out_ready. flush
// overrides both sides for that cycle.
module instr_field_queue
  import mips_fields_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [REG_W-1:0]     out_rs,
  output logic [REG_W-1:0]     out_rt,
  output logic [REG_W-1:0]     out_rd,
  output logic [SHAMT_W-1:0]   out_shamt,
  output logic [FUNCT_W-1:0]   out_funct,
  output logic [IMM_W-1:0]     out_imm,
  output logic [INSTR_W-1:0]   out_imm_sext,
  output logic [INSTR_W-1:0]   out_imm_zext,
  output logic [PC_W-1:0]      out_jtarget,
  output logic                 out_nop,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  fields_t            head_f;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage array carries no reset; only occupancy decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // Pointers wrap explicitly at DEPTH-1; count alone tracks full/empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head entry, zeroed when the queue is empty so every data output reads 0
  always_comb begin
    head_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    head_instr = out_valid ? mem_instr[rd_ptr] : '0;
  end

  instr_fields u_fields (
    .instr    (head_instr),
    .fields   (head_f),
    .imm_sext (out_imm_sext),
    .imm_zext (out_imm_zext)
  );

  // Field outputs straight from the splitter on the (gated) head word
  always_comb begin
    out_pc     = head_pc;
    out_instr  = head_instr;
    out_opcode = head_f.opcode;
    out_rs     = head_f.rs;
    out_rt     = head_f.rt;
    out_rd     = head_f.rd;
    out_shamt  = head_f.shamt;
    out_funct  = head_f.funct;
    out_imm    = head_f.imm;
    out_nop    = out_valid & (head_instr == '0);
  end

  // J target keeps the upper bits of pc+4; only the carry into bit 28 matters
  generate
    if (PC_W > 28) begin : g_jt_wide
      logic [PC_W-29:0] pc4_hi;
      always_comb begin
        pc4_hi      = head_pc[PC_W-1:28] + (PC_W-28)'(&head_pc[27:2]);
        out_jtarget = out_valid ? {pc4_hi, head_f.jadd, 2'b00} : '0;
      end
    end else begin : g_jt_narrow
      always_comb begin
        out_jtarget = out_valid ? {head_f.jadd, 2'b00} : '0;
      end
    end
  endgenerate

endmodule
